// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit, shift-add multiply and restoring
// divide at one bit per cycle, with valid/ready handshakes on both sides.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_LENGTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Flush,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic [OP_LENGTH-1:0]  Operation,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_WIDTH-1:0] Result
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [W-1:0]    opd_q, opd_d, res_q, res_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic            is_div, a_sgn, b_sgn, neg_a, neg_b, div_zero, ovf;
  logic [W-1:0]    mag_a, mag_b, sp_res, dsel, fin;
  logic [W:0]      mul_sum, rem_sh, diff;
  logic [2*W-1:0]  step, fprod;
  always_comb begin
    is_div   = Operation[2];
    a_sgn    = is_div ? !Operation[0] : (Operation[1:0] != 2'b11);
    b_sgn    = is_div ? !Operation[0] : !Operation[1];
    neg_a    = a_sgn & SrcA[W-1];
    neg_b    = b_sgn & SrcB[W-1];
    mag_a    = neg_a ? -SrcA : SrcA;
    mag_b    = neg_b ? -SrcB : SrcB;
    div_zero = is_div && (SrcB == '0);
    ovf      = is_div && !Operation[0] && (SrcA == {1'b1, {(W-1){1'b0}}}) && (&SrcB);
    sp_res   = div_zero ? (Operation[1] ? SrcA : '1) : (Operation[1] ? '0 : {1'b1, {(W-1){1'b0}}});
    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    rem_sh   = acc_q[2*W-1:W-1];
    diff     = rem_sh - {1'b0, opd_q};
    step     = op_q[2] ? {diff[W] ? rem_sh[W-1:0] : diff[W-1:0], acc_q[W-2:0], ~diff[W]}
                       : {mul_sum, acc_q[W-1:1]};
    fprod    = neg_q ? -step : step;
    dsel     = op_q[1] ? step[2*W-1:W] : step[W-1:0];
    fin      = op_q[2] ? (neg_q ? -dsel : dsel) : (op_q[1:0] == 2'b00 ? fprod[W-1:0] : fprod[2*W-1:W]);
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    opd_d   = opd_q;
    acc_d   = acc_q;
    res_d   = res_q;
    if (Flush) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (InValid) begin
          op_d    = Operation[2:0];
          neg_d   = (is_div && Operation[1]) ? neg_a : neg_a ^ neg_b;
          opd_d   = is_div ? mag_b : mag_a;
          acc_d   = {{W{1'b0}}, is_div ? mag_a : mag_b};
          cnt_d   = CW'(W);
          state_d = (div_zero || ovf) ? DONE : CALC;
          res_d   = (div_zero || ovf) ? sp_res : res_q;
        end
        CALC: begin
          acc_d   = step;
          cnt_d   = cnt_q - CW'(1);
          state_d = (cnt_q == CW'(1)) ? DONE : CALC;
          res_d   = (cnt_q == CW'(1)) ? fin : res_q;
        end
        DONE:    state_d = OutReady ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      opd_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      opd_q   <= opd_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end
  assign InReady  = (state_q == IDLE);
  assign OutValid = (state_q == DONE);
  assign Result   = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit covering arithmetic, latency,
// special divide cases, backpressure, flush and asynchronous reset.
module tb_muldiv_unit;
  localparam int W = 32;
  logic         clk = 1'b0, rst_n = 1'b0, Flush = 1'b0, InValid = 1'b0, OutReady = 1'b0;
  logic         InReady, OutValid;
  logic [W-1:0] SrcA = '0, SrcB = '0, Result;
  logic [2:0]   Operation = '0;
  int           n_cmp = 0, n_err = 0, lat;
  always #5 clk = ~clk;
  muldiv_unit #(.DATA_WIDTH(W), .OP_LENGTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .OutValid(OutValid),
    .OutReady(OutReady), .Result(Result)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Operation = op; SrcA = a; SrcB = b; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0; SrcA = $urandom; SrcB = $urandom; Operation = 3'($urandom);
  endtask
  task automatic wait_valid(output int n);
    n = 1;
    while (!OutValid && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask
  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int n;
    OutReady = 1'b1;
    accept(op, a, b);
    wait_valid(n);
    chk({tag, "_lat"}, n, exp_lat);
    chk(tag, Result, exp);
    @(posedge clk); #1;
    chk({tag, "_drop"}, {31'b0, OutValid}, 32'd0);
    chk({tag, "_rdy"}, {31'b0, InReady}, 32'd1);
  endtask
  initial begin
    #1;
    chk("rst_inready", {31'b0, InReady}, 32'd1);
    chk("rst_outvalid", {31'b0, OutValid}, 32'd0);
    chk("rst_result", Result, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run("mul_7x-3",  3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run("mulhu_ff",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run("mulh_ff",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run("mulhsu_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run("mul_big",   3'b000, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 33);
    run("mulhu_big", 3'b011, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 33);
    run("div_-7/2",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run("rem_-7/2",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run("divu_big",  3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
    run("div_7/-2",  3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run("rem_7/-2",  3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run("remu_100/7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    run("divu_5/0",  3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("remu_5/0",  3'b111, 32'd5, 32'd0, 32'd5, 1);
    run("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run("divu_ovfop", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    // backpressure: result must hold while OutReady stays low
    OutReady = 1'b0;
    accept(3'b000, 32'd6, 32'd7);
    wait_valid(lat);
    chk("stall_lat", lat, 33);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'b0, OutValid}, 32'd1);
      chk("stall_result", Result, 32'd42);
      chk("stall_inready", {31'b0, InReady}, 32'd0);
    end
    OutReady = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_valid", {31'b0, OutValid}, 32'd0);
    chk("stall_release_rdy", {31'b0, InReady}, 32'd1);
    // flush mid-calculation
    accept(3'b000, 32'd1000, 32'd1000);
    repeat (9) @(posedge clk);
    #1 Flush = 1'b1;
    @(posedge clk); #1 Flush = 1'b0;
    chk("flush_valid", {31'b0, OutValid}, 32'd0);
    chk("flush_rdy", {31'b0, InReady}, 32'd1);
    run("flush_mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 33);
    // flush while holding a result
    OutReady = 1'b0;
    accept(3'b101, 32'd5, 32'd0);
    chk("flushdone_pre", {31'b0, OutValid}, 32'd1);
    Flush = 1'b1;
    @(posedge clk); #1 Flush = 1'b0;
    chk("flushdone_valid", {31'b0, OutValid}, 32'd0);
    chk("flushdone_rdy", {31'b0, InReady}, 32'd1);
    // asynchronous reset mid-calculation
    OutReady = 1'b1;
    accept(3'b000, 32'd1000, 32'd1000);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdy", {31'b0, InReady}, 32'd1);
    chk("arst_valid", {31'b0, OutValid}, 32'd0);
    chk("arst_result", Result, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run("arst_mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 33);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
